pll_scan_sequencer: RTL and testbench

// Consumes the bit-serial PLL config from pll_reconf_rom and reprograms the video PLL through its scan chain.
// - On the ROM's trigger_read pulse, reads SCAN_LEN bits from the ROM into a local buffer.
// - Shifts the buffer into the PLL, issues configupdate, then waits for scandone.
// - Drives busy back to the ROM's pll_reconf_busy input, so a mode change is never re-triggered mid-sequence.

---
 rtl/pll_scan_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pll_scan_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_scan_sequencer.sv
// PLL scan-chain sequencer: pulls SCAN_LEN bits from the bit-serial reconfig ROM, shifts them
// into the PLL (MSB first), pulses configupdate and waits for scandone. Watchdog: PLL_SCAN_TIMEOUT_EN.
module pll_scan_sequencer #(
    parameter int SCAN_LEN    = 144,
    parameter int ADDR_W      = 8,
    parameter int ROM_LATENCY = 2,
    parameter int SCANCLK_DIV = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_ena,
    input  logic              rom_q,
    input  logic              rom_reconfig,
    output logic              busy,
    output logic              done,
    output logic              pll_scanclk,
    output logic              pll_scanclkena,
    output logic              pll_scandata,
    output logic              pll_configupdate,
    input  logic              pll_scandone,
    output logic              error
);
    localparam int CNT_W = $clog2(SCAN_LEN + 1);
    localparam int DIV_W = $clog2(SCANCLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(ROM_LATENCY - 1);
    localparam logic [DIV_W-1:0] LAST_DIV   = DIV_W'(SCANCLK_DIV - 1);

    if (SCAN_LEN > 2**ADDR_W || SCAN_LEN < 1 || ROM_LATENCY < 1 || SCANCLK_DIV < 1 ||
        TIMEOUT_CYC < 1) begin : g_param_check
        $error("pll_scan_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE, LOAD, DRAIN, SHIFT, WAIT_RECONF, UPDATE, WAIT_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt;      // LOAD address, DRAIN cycles, SHIFT bits sent
    logic [CNT_W-1:0]       wr_idx;
    logic [DIV_W-1:0]       div_cnt;
    logic [SCAN_LEN-1:0]    chain;
    logic [ROM_LATENCY-1:0] rd_vld_pipe;
    logic                   sclk;
    logic                   recfg_seen;
    logic [2:0]             sd_sync;
    logic                   sd_rise;
    logic                   half_end;
    logic                   shift_last;
    logic                   timeout;
    logic                   done_q;

    assign sd_rise    = sd_sync[1] & ~sd_sync[2];
    assign half_end   = (state == SHIFT) && (div_cnt == LAST_DIV);
    assign shift_last = half_end && sclk && (cnt == LAST_BIT);

`ifdef PLL_SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            err_q;

    assign waiting = (state == WAIT_RECONF) || (state == WAIT_DONE);
    assign timeout = waiting && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign error   = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == IDLE && start) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (timeout) begin
            err_q  <= 1'b1;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (start) state_nxt = LOAD;
            LOAD:        if (cnt == LAST_BIT) state_nxt = DRAIN;
            DRAIN:       if (cnt == LAST_DRAIN) state_nxt = SHIFT;
            SHIFT:       if (shift_last) state_nxt = WAIT_RECONF;
            WAIT_RECONF: begin
                if (timeout)                         state_nxt = IDLE;
                else if (recfg_seen || rom_reconfig) state_nxt = UPDATE;
            end
            UPDATE:      state_nxt = WAIT_DONE;
            WAIT_DONE:   if (timeout || sd_rise) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_idx      <= '0;
            div_cnt     <= '0;
            chain       <= '0;
            rd_vld_pipe <= '0;
            sclk        <= 1'b0;
            recfg_seen  <= 1'b0;
            sd_sync     <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            sd_sync     <= {sd_sync[1:0], pll_scandone};
            done_q      <= (state == WAIT_DONE) && sd_rise && !timeout;
            rd_vld_pipe <= (rd_vld_pipe << 1) | ROM_LATENCY'(rom_read_ena);

            if (state == IDLE && start)
                recfg_seen <= 1'b0;
            else if (state != IDLE && rom_reconfig)
                recfg_seen <= 1'b1;

            // rom_q for address a lands ROM_LATENCY clocks later; addresses are sequential
            if (rd_vld_pipe[ROM_LATENCY-1]) begin
                chain[wr_idx] <= rom_q;
                wr_idx        <= wr_idx + 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    wr_idx  <= '0;
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                end
                LOAD:  cnt <= (cnt == LAST_BIT)   ? '0 : cnt + 1'b1;
                DRAIN: cnt <= (cnt == LAST_DRAIN) ? '0 : cnt + 1'b1;
                SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // next bit presented on the falling edge, a full low phase ahead of the rise
                        if (sclk) begin
                            cnt   <= cnt + 1'b1;
                            chain <= chain << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign done             = done_q;
    assign rom_read_ena     = (state == LOAD);
    assign rom_address      = (state == LOAD) ? ADDR_W'(cnt) : '0;
    assign pll_scanclkena   = (state == SHIFT);
    assign pll_scanclk      = (state == SHIFT) & sclk;
    assign pll_scandata     = (state == SHIFT) & chain[SCAN_LEN-1];
    assign pll_configupdate = (state == UPDATE);
endmodule

// File: tb/tb_pll_scan_sequencer.sv
// Randomised bench for pll_scan_sequencer: behavioural ROM and PLL, expected chain order and
// event timing derived from the sequencing rules (load, drain, shift, reconfig, update, scandone).
module tb_pll_scan_sequencer;
    localparam int SCAN_LEN = 144;
    localparam int ADDR_W   = 8;
    localparam int LAT      = 2;
    localparam int DIV      = 2;
    localparam int TMO      = 100;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              rom_reconfig = 1'b0;
    logic              pll_scandone = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_read_ena, rom_q, busy, done, error;
    logic              pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate;

    pll_scan_sequencer #(
        .SCAN_LEN(SCAN_LEN), .ADDR_W(ADDR_W), .ROM_LATENCY(LAT),
        .SCANCLK_DIV(DIV), .TIMEOUT_CYC(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .rom_address(rom_address), .rom_read_ena(rom_read_ena), .rom_q(rom_q),
        .rom_reconfig(rom_reconfig), .busy(busy), .done(done),
        .pll_scanclk(pll_scanclk), .pll_scanclkena(pll_scanclkena),
        .pll_scandata(pll_scandata), .pll_configupdate(pll_configupdate),
        .pll_scandone(pll_scandone), .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ROM: registered address pipeline, LAT clocks from address to data
    logic [SCAN_LEN-1:0] rom_bits = '0;
    logic [ADDR_W-1:0]   a_d1 = '0, a_d2 = '0;
    always @(posedge clock) begin
        a_d1 <= rom_address;
        a_d2 <= a_d1;
    end
    assign rom_q = (a_d2 < SCAN_LEN) ? rom_bits[a_d2] : 1'b0;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   rd_n, rd_first, rd_last, addr_bad;
    int   rise_n, last_rise, data_chg, period_bad, setup_bad, hold_bad, chain_bad;
    int   upd_n, upd_cyc, done_n, done_cyc, busy_n, busy_at_done;
    logic sclk_p = 1'b0, sdata_p = 1'b0;

    always @(negedge clock) begin
        if (rom_read_ena) begin
            if (rd_n == 0) rd_first = cyc;
            if (int'(rom_address) != rd_n) addr_bad++;
            rd_n++;
            rd_last = cyc;
        end
        if (pll_scandata != sdata_p) begin
            data_chg = cyc;
            if (pll_scanclk && sclk_p) hold_bad++;
        end
        if (pll_scanclk && !sclk_p) begin
            // k-th rising edge must carry ROM bit SCAN_LEN-1-k
            if (rise_n < SCAN_LEN && pll_scandata !== rom_bits[SCAN_LEN-1-rise_n]) chain_bad++;
            if (cyc - data_chg < DIV) setup_bad++;
            if (rise_n > 0 && cyc - last_rise != 2*DIV) period_bad++;
            last_rise = cyc;
            rise_n++;
        end
        if (pll_configupdate) begin upd_n++; upd_cyc = cyc; end
        if (done) begin done_n++; done_cyc = cyc; busy_at_done = int'(busy); end
        if (busy) busy_n++;
        sclk_p  = pll_scanclk;
        sdata_p = pll_scandata;
    end

    task automatic clr_mon();
        rd_n = 0; rd_first = 0; rd_last = 0; addr_bad = 0;
        rise_n = 0; last_rise = 0; data_chg = 0;
        period_bad = 0; setup_bad = 0; hold_bad = 0; chain_bad = 0;
        upd_n = 0; upd_cyc = 0; done_n = 0; done_cyc = 0; busy_n = 0; busy_at_done = 0;
    endtask

    task automatic new_pattern();
        for (int i = 0; i < SCAN_LEN; i++) rom_bits[i] = 1'($urandom);
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin @(posedge clock); #1; end
    endtask

    task automatic do_start(output int t);
        @(posedge clock); #1;
        start = 1'b1;
        t = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    function automatic int outs_vec();
        return int'({busy, done, rom_read_ena, rom_address, pll_scanclk, pll_scanclkena,
                     pll_scandata, pll_configupdate, error});
    endfunction

    // first WAIT_RECONF cycle for a start accepted in cycle t
    function automatic int wr_cycle(input int t);
        return t + 1 + SCAN_LEN + LAT + 2*DIV*SCAN_LEN;
    endfunction

    // rmode: 0 reconfig inside SHIFT, 1 50 clk after SHIFT, 2 on SHIFT end, 3 one clk later
    task automatic run_seq(input string nm, input int rmode, input bit dbl);
        int t, r, wr, upd_exp, x;
        new_pattern();
        clr_mon();
        do_start(t);
        wr = wr_cycle(t);
        case (rmode)
            0:       r = t + 170 + int'($urandom_range(0, 500));
            1:       r = wr + 50;
            2:       r = wr;
            default: r = wr + 1;
        endcase
        chk({nm, "_busy_t1"}, int'(busy), 1);
        if (dbl) begin
            step_to(t + 160);
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
        end
        step_to(r);
        rom_reconfig = 1'b1;
        @(posedge clock); #1;
        rom_reconfig = 1'b0;
        upd_exp = ((r > wr) ? r : wr) + 1;
        step_to(upd_exp + 5);
        chk({nm, "_upd_cnt"}, upd_n, 1);
        chk({nm, "_upd_cyc"}, upd_cyc - t, upd_exp - t);
        chk({nm, "_rd_first"}, rd_first - t, 1);
        chk({nm, "_rd_last"}, rd_last - t, SCAN_LEN);
        chk({nm, "_rd_cnt"}, rd_n, SCAN_LEN);
        chk({nm, "_addr_bad"}, addr_bad, 0);
        chk({nm, "_rises"}, rise_n, SCAN_LEN);
        chk({nm, "_chain_bad"}, chain_bad, 0);
        chk({nm, "_period_bad"}, period_bad, 0);
        chk({nm, "_setup_bad"}, setup_bad, 0);
        chk({nm, "_hold_bad"}, hold_bad, 0);
        chk({nm, "_done_early"}, done_n, 0);
        x = cyc + int'($urandom_range(1, 8));
        step_to(x);
        pll_scandone = 1'b1;
        step_to(x + 10);
        chk({nm, "_done_cnt"}, done_n, 1);
        chk({nm, "_done_lat"}, done_cyc - x, 3);
        chk({nm, "_busy_at_done"}, busy_at_done, 0);
        chk({nm, "_busy_cycles"}, busy_n, done_cyc - t - 1);
        pll_scandone = 1'b0;
        step_to(cyc + 5);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 50000);
        $fatal(1, "bench timeout");
    end

    initial begin
        int t, wr;
        clr_mon();
        #3;
        chk("reset_outs", outs_vec(), 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        step_to(cyc + 2);
        chk("idle_outs", outs_vec(), 0);

        run_seq("shift_recfg", 0, 1'b0);
        run_seq("late_recfg", 1, 1'b0);
        run_seq("edge_recfg", 2, 1'b0);
        run_seq("edge1_recfg", 3, 1'b0);
        run_seq("dbl_start", 0, 1'b1);
        run_seq("rand_recfg", 0, 1'b0);

        // abort mid-SHIFT, then a full rerun with a fresh pattern
        new_pattern();
        clr_mon();
        do_start(t);
        step_to(t + 400);
        chk("mid_busy", int'(busy), 1);
        chk("mid_scanena", int'(pll_scanclkena), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outs", outs_vec(), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        step_to(cyc + 3);
        run_seq("after_reset", 0, 1'b0);

`ifdef PLL_SCAN_TIMEOUT_EN
        new_pattern();
        clr_mon();
        do_start(t);
        wr = wr_cycle(t);
        step_to(t + 300);
        rom_reconfig = 1'b1;
        @(posedge clock); #1;
        rom_reconfig = 1'b0;
        step_to(wr + 90);
        chk("tmo_busy_before", int'(busy), 1);
        chk("tmo_err_before", int'(error), 0);
        step_to(wr + 110);
        chk("tmo_err", int'(error), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_no_done", done_n, 0);
        chk("tmo_upd", upd_n, 1);
        do_start(t);
        chk("tmo_err_clr", int'(error), 0);
        chk("tmo_restart_busy", int'(busy), 1);
        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        step_to(cyc + 3);
        run_seq("post_tmo", 1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
